// File: rtl/txpippm_sequencer.sv
// ---------------------------------------------------------------------------
// txpippm_sequencer
//
// Issues a burst of TX phase-interpolator PPM steps to a group of GT
// channels. A rising edge on start_in in IDLE captures the channel mask,
// step count and step size. The sequencer then raises TXPIPPMEN on the
// selected channels for EN_WIDTH cycles per step. Consecutive steps are
// separated by GAP_CYCLES low cycles. After the last step it emits a
// one-cycle done strobe.
//
// Ports:
//   gtwiz_userclk_tx_usrclk_in  TXUSRCLK, the only clock (rising edge)
//   gtwiz_reset_all_in          synchronous active-high reset
//   sel_in                      per-channel step enable mask
//   start_in                    request level, each rising edge = request
//   abort_in                    abort a running sequence
//   step_count_in               number of PI steps to issue
//   stepsize_in                 step magnitude
//   dir_in                      step direction (stepsize bit 4)
//   txpippmen_out               per-channel TXPIPPMEN
//   txpippmovrden_out           constant 0
//   txpippmsel_out              constant all ones
//   txpippmpd_out               constant 0
//   txpippmstepsize_out         {dir, magnitude} replicated per channel
//   busy_out                    high while pulses/gaps are being issued
//   done_out                    one-cycle completion strobe
//   steps_remaining_out         steps not yet issued
//   state_out                   debug view of the FSM state
// ---------------------------------------------------------------------------
module txpippm_sequencer #(
  parameter int CHANNEL_COUNT = 10,
  parameter int EN_WIDTH      = 2,
  parameter int GAP_CYCLES    = 4,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                       gtwiz_userclk_tx_usrclk_in,
  input  logic                       gtwiz_reset_all_in,
  input  logic [CHANNEL_COUNT-1:0]   sel_in,
  input  logic                       start_in,
  input  logic                       abort_in,
  input  logic [COUNT_WIDTH-1:0]     step_count_in,
  input  logic [3:0]                 stepsize_in,
  input  logic                       dir_in,
  output logic [CHANNEL_COUNT-1:0]   txpippmen_out,
  output logic [CHANNEL_COUNT-1:0]   txpippmovrden_out,
  output logic [CHANNEL_COUNT-1:0]   txpippmsel_out,
  output logic [CHANNEL_COUNT-1:0]   txpippmpd_out,
  output logic [CHANNEL_COUNT*5-1:0] txpippmstepsize_out,
  output logic                       busy_out,
  output logic                       done_out,
  output logic [COUNT_WIDTH-1:0]     steps_remaining_out,
  output logic [1:0]                 state_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PULSE = 2'b01,
    GAP   = 2'b11,
    DONE  = 2'b10
  } state_t;

  state_t                   state;
  state_t                   next_state;
  logic                     start_q;
  logic                     armed;
  logic [7:0]               timer;
  logic [CHANNEL_COUNT-1:0] sel_q;
  logic [COUNT_WIDTH-1:0]   remaining;
  logic [4:0]               stepsize_q;

  logic start_edge;
  logic pulse_end;
  logic gap_end;
  logic last_step;

  // armed blocks a start_in that was already high when reset released
  // from being seen as a request until it has been observed low once.
  assign start_edge = start_in & ~start_q & armed;
  assign pulse_end  = (state == PULSE) && (timer == 8'(EN_WIDTH - 1));
  assign gap_end    = (state == GAP)   && (timer == 8'(GAP_CYCLES - 1));
  assign last_step  = (remaining == COUNT_WIDTH'(1));

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_edge)
          next_state = (step_count_in != '0) ? PULSE : DONE;
      end
      PULSE: begin
        if (abort_in)
          next_state = IDLE;
        else if (pulse_end)
          next_state = last_step ? DONE : GAP;
      end
      GAP: begin
        if (abort_in)
          next_state = IDLE;
        else if (gap_end)
          next_state = PULSE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The timer restarts on every state change so it measures the time
  // spent in the current PULSE or GAP interval.
  always_ff @(posedge gtwiz_userclk_tx_usrclk_in) begin
    if (gtwiz_reset_all_in) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      armed      <= 1'b0;
      timer      <= '0;
      sel_q      <= '0;
      remaining  <= '0;
      stepsize_q <= '0;
    end else begin
      state   <= next_state;
      start_q <= start_in;
      if (!start_in)
        armed <= 1'b1;
      if ((next_state != state) || (state == IDLE) || (state == DONE))
        timer <= '0;
      else
        timer <= timer + 8'd1;
      if ((state == IDLE) && start_edge) begin
        sel_q      <= sel_in;
        remaining  <= step_count_in;
        stepsize_q <= {dir_in, stepsize_in};
      end
      // An aborted pulse does not count as issued.
      if (pulse_end && !abort_in)
        remaining <= remaining - COUNT_WIDTH'(1);
    end
  end

  assign txpippmen_out       = (state == PULSE) ? sel_q : '0;
  assign txpippmovrden_out   = '0;
  assign txpippmsel_out      = '1;
  assign txpippmpd_out       = '0;
  assign txpippmstepsize_out = {CHANNEL_COUNT{stepsize_q}};
  assign busy_out            = (state == PULSE) || (state == GAP);
  assign done_out            = (state == DONE);
  assign steps_remaining_out = remaining;
  assign state_out           = state;

endmodule

// File: tb/tb_txpippm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_txpippm_sequencer
//
// Bench for txpippm_sequencer. Drives requests on a default-parameter
// instance and on a fast instance (EN_WIDTH=1, GAP_CYCLES=1). A reference
// model builds the expected cycle-by-cycle trace of a request straight from
// the pulse/gap/done timing rules, and each test walks that trace.
// ---------------------------------------------------------------------------
module tb_txpippm_sequencer;

  typedef struct packed {
    logic [9:0] en;
    logic       busy;
    logic       done;
    logic [7:0] rem;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  sel;
  logic        start_a;
  logic        start_b;
  logic        abort;
  logic [7:0]  count;
  logic [3:0]  mag;
  logic        dir;

  logic [9:0]  en_a, ovr_a, psel_a, pd_a;
  logic [49:0] ss_a;
  logic        busy_a, done_a;
  logic [7:0]  rem_a;
  logic [1:0]  st_a;

  logic [9:0]  en_b, ovr_b, psel_b, pd_b;
  logic [49:0] ss_b;
  logic        busy_b, done_b;
  logic [7:0]  rem_b;
  logic [1:0]  st_b;

  int   vectors = 0;
  int   errors  = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  txpippm_sequencer dut (
    .gtwiz_userclk_tx_usrclk_in (clk),
    .gtwiz_reset_all_in         (rst),
    .sel_in                     (sel),
    .start_in                   (start_a),
    .abort_in                   (abort),
    .step_count_in              (count),
    .stepsize_in                (mag),
    .dir_in                     (dir),
    .txpippmen_out              (en_a),
    .txpippmovrden_out          (ovr_a),
    .txpippmsel_out             (psel_a),
    .txpippmpd_out              (pd_a),
    .txpippmstepsize_out        (ss_a),
    .busy_out                   (busy_a),
    .done_out                   (done_a),
    .steps_remaining_out        (rem_a),
    .state_out                  (st_a)
  );

  txpippm_sequencer #(.EN_WIDTH(1), .GAP_CYCLES(1)) dut_fast (
    .gtwiz_userclk_tx_usrclk_in (clk),
    .gtwiz_reset_all_in         (rst),
    .sel_in                     (sel),
    .start_in                   (start_b),
    .abort_in                   (abort),
    .step_count_in              (count),
    .stepsize_in                (mag),
    .dir_in                     (dir),
    .txpippmen_out              (en_b),
    .txpippmovrden_out          (ovr_b),
    .txpippmsel_out             (psel_b),
    .txpippmpd_out              (pd_b),
    .txpippmstepsize_out        (ss_b),
    .busy_out                   (busy_b),
    .done_out                   (done_b),
    .steps_remaining_out        (rem_b),
    .state_out                  (st_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected trace of one request, starting the cycle after the start edge:
  // n steps of enw cycles high, gap cycles low between steps, then a
  // single done cycle.
  task automatic build_model(input int n, input logic [9:0] s,
                             input int enw, input int gap);
    exp_t e;
    q.delete();
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < enw; c++) begin
        e = {s, 1'b1, 1'b0, 8'(n - i)};
        q.push_back(e);
      end
      if (i < n - 1)
        for (int c = 0; c < gap; c++) begin
          e = {10'h0, 1'b1, 1'b0, 8'(n - i - 1)};
          q.push_back(e);
        end
    end
    e = {10'h0, 1'b0, 1'b1, 8'h0};
    q.push_back(e);
  endtask

  task automatic request_a(input int n, input logic [9:0] s,
                           input logic [3:0] m, input logic d);
    sel = s; count = 8'(n); mag = m; dir = d;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if ({st_a, en_a, busy_a, done_a, rem_a} !== 22'h0) begin
      errors++;
      $display("[TB] FAIL reset_state got st=%b en=%h busy=%b done=%b rem=%0d required all 0",
               st_a, en_a, busy_a, done_a, rem_a);
    end
    vectors++;
    if (ss_a !== 50'h0) begin
      errors++;
      $display("[TB] FAIL reset_stepsize got %h required 0", ss_a);
    end
    vectors++;
    if ({ovr_a, psel_a, pd_a} !== {10'h0, 10'h3ff, 10'h0}) begin
      errors++;
      $display("[TB] FAIL const_outputs got ovr=%h sel=%h pd=%h required 0/3ff/0",
               ovr_a, psel_a, pd_a);
    end
    vectors++;
    if ({st_b, busy_b, rem_b} !== 11'h0) begin
      errors++;
      $display("[TB] FAIL reset_fast got st=%b busy=%b rem=%0d required 0", st_b, busy_b, rem_b);
    end
    rst = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_basic();
    int          n;
    logic [9:0]  s;
    logic [3:0]  m;
    logic        d;
    for (int r = 0; r < 5; r++) begin
      if (r == 0) begin
        n = 3; s = 10'h005; m = 4'h3; d = 1'b1;
      end else begin
        n = $urandom_range(1, 6); s = 10'($urandom); m = 4'($urandom); d = 1'($urandom);
      end
      build_model(n, s, 2, 4);
      request_a(n, s, m, d);
      for (int k = 0; k < q.size(); k++) begin
        vectors++;
        if ({en_a, busy_a, done_a, rem_a, ss_a} !== {q[k], {10{d, m}}}) begin
          errors++;
          $display("[TB] FAIL basic run=%0d cyc=%0d got en=%h busy=%b done=%b rem=%0d ss=%h required %h ss=%h",
                   r, k, en_a, busy_a, done_a, rem_a, ss_a, q[k], {10{d, m}});
        end
        tick();
      end
      vectors++;
      if ({st_a, en_a, busy_a, done_a, ss_a} !== {2'b00, 10'h0, 2'b00, {10{d, m}}}) begin
        errors++;
        $display("[TB] FAIL basic_idle run=%0d got st=%b en=%h busy=%b done=%b ss=%h",
                 r, st_a, en_a, busy_a, done_a, ss_a);
      end
      tick();
    end
  endtask

  task automatic test_zero_count();
    build_model(0, 10'h3ff, 2, 4);
    request_a(0, 10'h3ff, 4'h7, 1'b0);
    vectors++;
    if ({en_a, busy_a, done_a, rem_a} !== q[0]) begin
      errors++;
      $display("[TB] FAIL zero_count got en=%h busy=%b done=%b rem=%0d required %h",
               en_a, busy_a, done_a, rem_a, q[0]);
    end
    tick();
    vectors++;
    if ({st_a, busy_a, done_a} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL zero_count_idle got st=%b busy=%b done=%b required idle",
               st_a, busy_a, done_a);
    end
    tick();
  endtask

  task automatic test_abort();
    // Abort during the second gap of a 5-step request.
    build_model(5, 10'h2a1, 2, 4);
    request_a(5, 10'h2a1, 4'h9, 1'b0);
    for (int k = 0; k <= 9; k++) begin
      vectors++;
      if ({en_a, busy_a, done_a, rem_a} !== q[k]) begin
        errors++;
        $display("[TB] FAIL abort_pre cyc=%0d got en=%h busy=%b done=%b rem=%0d required %h",
                 k, en_a, busy_a, done_a, rem_a, q[k]);
      end
      if (k == 9) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    vectors++;
    if ({st_a, en_a, busy_a, done_a, rem_a} !== {2'b00, 10'h0, 2'b00, 8'd3}) begin
      errors++;
      $display("[TB] FAIL abort_gap got st=%b en=%h busy=%b done=%b rem=%0d required idle rem=3",
               st_a, en_a, busy_a, done_a, rem_a);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      vectors++;
      if ({done_a, busy_a, rem_a} !== {2'b00, 8'd3}) begin
        errors++;
        $display("[TB] FAIL abort_quiet cyc=%0d got done=%b busy=%b rem=%0d required 0/0/3",
                 k, done_a, busy_a, rem_a);
      end
    end
    // Abort during the second pulse together with a fresh start edge.
    build_model(4, 10'h0ff, 2, 4);
    request_a(4, 10'h0ff, 4'h1, 1'b1);
    for (int k = 0; k <= 6; k++) begin
      vectors++;
      if ({en_a, busy_a, done_a, rem_a} !== q[k]) begin
        errors++;
        $display("[TB] FAIL abort2_pre cyc=%0d got en=%h busy=%b done=%b rem=%0d required %h",
                 k, en_a, busy_a, done_a, rem_a, q[k]);
      end
      if (k == 6) begin
        abort   = 1'b1;
        start_a = 1'b1;
      end
      tick();
    end
    abort = 1'b0;
    vectors++;
    if ({st_a, en_a, done_a, rem_a} !== {2'b00, 10'h0, 1'b0, 8'd3}) begin
      errors++;
      $display("[TB] FAIL abort_pulse got st=%b en=%h done=%b rem=%0d required idle rem=3",
               st_a, en_a, done_a, rem_a);
    end
    tick();
    vectors++;
    if ({st_a, busy_a} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL abort_priority got st=%b busy=%b required idle", st_a, busy_a);
    end
    start_a = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    build_model(3, 10'h155, 2, 4);
    request_a(3, 10'h155, 4'h5, 1'b0);
    for (int k = 0; k < q.size(); k++) begin
      vectors++;
      if ({en_a, busy_a, done_a, rem_a} !== q[k]) begin
        errors++;
        $display("[TB] FAIL restart_ignored cyc=%0d got en=%h busy=%b done=%b rem=%0d required %h",
                 k, en_a, busy_a, done_a, rem_a, q[k]);
      end
      if (k == 3) begin
        count   = 8'd9;
        start_a = 1'b1;
      end
      if (k == 5) start_a = 1'b0;
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      vectors++;
      if ({st_a, en_a, busy_a} !== 13'h0) begin
        errors++;
        $display("[TB] FAIL restart_queued cyc=%0d got st=%b en=%h busy=%b required idle",
                 k, st_a, en_a, busy_a);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    sel = 10'h3c3; count = 8'd3; mag = 4'ha; dir = 1'b1;
    start_a = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    vectors++;
    if ({st_a, en_a, busy_a, done_a, rem_a, ss_a} !== 72'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid got st=%b en=%h busy=%b done=%b rem=%0d ss=%h required 0",
               st_a, en_a, busy_a, done_a, rem_a, ss_a);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      vectors++;
      if ({st_a, en_a, busy_a, done_a} !== 14'h0) begin
        errors++;
        $display("[TB] FAIL held_start cyc=%0d got st=%b en=%h busy=%b done=%b required idle",
                 k, st_a, en_a, busy_a, done_a);
      end
    end
    start_a = 1'b0;
    tick();
    build_model(3, 10'h3c3, 2, 4);
    start_a = 1'b1;
    tick();
    for (int k = 0; k < q.size(); k++) begin
      vectors++;
      if ({en_a, busy_a, done_a, rem_a} !== q[k]) begin
        errors++;
        $display("[TB] FAIL after_toggle cyc=%0d got en=%h busy=%b done=%b rem=%0d required %h",
                 k, en_a, busy_a, done_a, rem_a, q[k]);
      end
      tick();
    end
    start_a = 1'b0;
    tick();
  endtask

  task automatic test_max_count();
    int dones = 0;
    int pulses = 0;
    build_model(255, 10'h000, 1, 1);
    sel = 10'h000; count = 8'd255; mag = 4'hf; dir = 1'b0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 0; k < q.size(); k++) begin
      vectors++;
      if ({en_b, busy_b, done_b, rem_b} !== q[k]) begin
        errors++;
        $display("[TB] FAIL max_count cyc=%0d got en=%h busy=%b done=%b rem=%0d required %h",
                 k, en_b, busy_b, done_b, rem_b, q[k]);
      end
      if (st_b == 2'b01) pulses++;
      if (done_b) dones++;
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      if (done_b) dones++;
      if (busy_b) pulses++;
      tick();
    end
    vectors++;
    if ({pulses, dones, rem_b} !== {32'd255, 32'd1, 8'd0}) begin
      errors++;
      $display("[TB] FAIL max_totals got pulses=%0d dones=%0d rem=%0d required 255/1/0",
               pulses, dones, rem_b);
    end
  endtask

  initial begin
    rst = 1'b1; sel = '0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
    count = '0; mag = '0; dir = 1'b0;
    test_reset();
    test_basic();
    test_zero_count();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_max_count();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout required completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/txpippm_sequencer.md
TXPIPPM_SEQUENCER -- requirements
Module: txpippm_sequencer

Interface
REQ-001 Parameter CHANNEL_COUNT, default 10, number of GT channels served.
REQ-002 Parameter EN_WIDTH, default 2, TXPIPPMEN high time per step in cycles; legal range 1..255.
REQ-003 Parameter GAP_CYCLES, default 4, minimum low time between consecutive steps in cycles; legal range 1..255.
REQ-004 Parameter COUNT_WIDTH, default 8, width of the step-count request.
REQ-005 gtwiz_userclk_tx_usrclk_in  in  1  TXUSRCLK; the only clock, all logic on its rising edge.
REQ-006 gtwiz_reset_all_in  in  1  reset; synchronous, active-high.
REQ-007 sel_in  in  CHANNEL_COUNT  per-channel step enable mask, captured at start.
REQ-008 start_in  in  1  request level; each rising edge is one request.
REQ-009 abort_in  in  1  synchronous abort of a running sequence.
REQ-010 step_count_in  in  COUNT_WIDTH  number of PI steps to issue, captured at start.
REQ-011 stepsize_in  in  4  step magnitude, captured at start.
REQ-012 dir_in  in  1  step direction (driven as stepsize bit 4), captured at start.
REQ-013 txpippmen_out  out  CHANNEL_COUNT  per-channel TXPIPPMEN.
REQ-014 txpippmovrden_out, txpippmsel_out, txpippmpd_out  out  CHANNEL_COUNT each  constant 0, all 1, and 0 respectively.
REQ-015 txpippmstepsize_out  out  CHANNEL_COUNT*5  captured {dir, magnitude}, replicated per channel.
REQ-016 busy_out  out  1  sequence in progress.
REQ-017 done_out  out  1  one-cycle completion strobe.
REQ-018 steps_remaining_out  out  COUNT_WIDTH  steps not yet issued.
REQ-019 state_out  out  2  debug view of the FSM state.

Function
REQ-020 FSM states SHALL be: IDLE=2'b00, PULSE=2'b01, GAP=2'b11, DONE=2'b10.
REQ-021 Start edge SHALL be start_in=1 with a registered previous start_in=0.
REQ-022 A start edge in IDLE SHALL capture sel_in, step_count_in, stepsize_in and dir_in on that clock edge.
REQ-023 Same edge transition: to PULSE if step_count_in != 0, else to DONE.
REQ-024 Start edges outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-025 PULSE SHALL last exactly EN_WIDTH cycles.
REQ-026 txpippmen_out SHALL equal captured sel during PULSE and all-zero in every other state.
REQ-027 On leaving PULSE, steps_remaining SHALL decrement by 1.
REQ-028 From PULSE, the FSM SHALL go to DONE if the post-decrement count is 0, else to GAP.
REQ-029 GAP SHALL last exactly GAP_CYCLES cycles, then the FSM SHALL return to PULSE.
REQ-030 DONE SHALL last one cycle with done_out=1, then go to IDLE.
REQ-031 busy_out SHALL be 1 in PULSE and GAP and 0 in IDLE and DONE.
REQ-032 The step count SHALL NOT wrap below 0; the maximum request 2^COUNT_WIDTH-1 SHALL run fully.
REQ-033 abort_in=1 in PULSE or GAP SHALL move the FSM to IDLE on the next edge, with no done strobe.
REQ-034 On abort, txpippmen_out SHALL be 0 from that edge, and steps_remaining_out SHALL hold the unissued count.
REQ-035 abort_in SHALL be ignored in IDLE and DONE.
REQ-036 abort_in SHALL take priority over a same-cycle start edge.
REQ-037 txpippmstepsize_out SHALL stay stable for the whole sequence and hold the last captured value in IDLE.
REQ-038 A captured sel of all-zero SHALL still run the full timing, with txpippmen_out remaining all-zero.

Reset
REQ-039 While gtwiz_reset_all_in=1 at a clock edge: state IDLE; all counters, captured registers and the start-edge register cleared; txpippmen_out=0; stepsize_out=0; busy_out=0; done_out=0; steps_remaining_out=0.
REQ-040 Reset mid-sequence SHALL end it at that edge without a done strobe.
REQ-041 start_in held high through reset release SHALL NOT count as an edge until it has been seen low.

Verification
REQ-042 Defaults, sel=10'h005, count=3, stepsize=4'h3, dir=1, start edge -> three 2-cycle en pulses on channels 0 and 2, each separated by 4 low cycles; stepsize_out=5'h13 per channel; one done strobe 1 cycle after the last pulse.
REQ-043 count=0 -> no en pulse; one cycle after the start edge, done_out=1 and busy_out never asserts.
REQ-044 count=5 with abort asserted during the 2nd GAP -> IDLE next edge, steps_remaining_out=3, no done strobe.
REQ-045 Second start edge while busy -> ignored; exactly the original count of pulses issued.
REQ-046 Reset asserted during PULSE, start_in held high through release -> all outputs 0; no new sequence until start_in toggles low then high.
REQ-047 count=255 with EN_WIDTH=1 and GAP_CYCLES=1 -> 255 pulses, steps_remaining_out reaches 0, no wrap, single done strobe.
